load_store_unit: RTL and testbench

- Memory-access stage between the 16-bit RISC datapath and Data_Memory.
- Accepts load/store requests from the execute stage over a valid/ready handshake.
- Holds stores in a write-behind store buffer and drives the shared single address port of Data_Memory.
- Forwards buffered store data to younger loads, so a load never reads stale memory.

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 118 +++++++++++
 tb/tb_load_store_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request, response and Data_Memory signals of the load/store unit.
// The slave modport is the LSU's view; master is the execute/memory side.
interface load_store_unit_if #(
  parameter int DATA_W = 16,
  parameter int PTR_W  = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              drain_req;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              sb_empty;
  logic [PTR_W:0]    sb_count;
  logic [DATA_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, drain_req, mem_read_data,
    output req_ready, rsp_valid, rsp_data, sb_empty, sb_count,
           mem_access_addr, mem_write_data, mem_write_en, mem_read
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, drain_req, mem_read_data,
    input  req_ready, rsp_valid, rsp_data, sb_empty, sb_count,
           mem_access_addr, mem_write_data, mem_write_en, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: write-behind store buffer with store-to-load forwarding,
// sharing the single Data_Memory address port between loads and buffer drains.
module load_store_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int CMP_W  = 3
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);
  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DATA_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic              accept, push, pop, load_acc;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  idx;
  logic [DATA_W-1:0] mem_addr, mem_wdata;
  logic              mem_we, mem_rd;

  assign bus.req_ready = (count_q != FULL) && !bus.drain_req;
  assign accept        = rst_n && bus.req_valid && bus.req_ready;
  assign push          = accept && bus.req_we;
  assign load_acc      = accept && !bus.req_we;
  // An accepted request owns the memory port, so drain only in idle-request cycles.
  assign pop           = !accept && (count_q != '0);

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && valid_q[idx] &&
          (addr_q[idx][CMP_W-1:0] == bus.req_addr[CMP_W-1:0])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_ONE;
      count_d         = count_q + CNT_ONE;
    end else if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_ONE;
      count_d         = count_q - CNT_ONE;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_rd    = 1'b0;
    if (load_acc) begin
      mem_rd   = 1'b1;
      mem_addr = bus.req_addr;
    end else if (pop) begin
      mem_we    = 1'b1;
      mem_addr  = addr_q[head_q];
      mem_wdata = data_q[head_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      rsp_valid_q <= load_acc;
      if (load_acc) rsp_data_q <= fwd_hit ? fwd_data : bus.mem_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.req_addr;
      data_q[tail_q] <= bus.req_wdata;
    end
  end

  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.sb_empty        = (count_q == '0);
  assign bus.sb_count        = count_q;
  assign bus.mem_access_addr = mem_addr;
  assign bus.mem_write_data  = mem_wdata;
  assign bus.mem_write_en    = mem_we;
  assign bus.mem_read        = mem_rd;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small 8-word Data_Memory model.
module tb_load_store_unit;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  load_store_unit_if #(.DATA_W(16), .PTR_W(2)) bus ();

  load_store_unit #(.DATA_W(16), .DEPTH(4), .PTR_W(2), .CMP_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] mem [8] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0F0F, 16'h0, 16'h0};
  assign bus.mem_read_data = mem[bus.mem_access_addr[2:0]];
  always @(posedge clk) if (bus.mem_write_en) mem[bus.mem_access_addr[2:0]] <= bus.mem_write_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [15:0] a,
                       input logic [15:0] d, input logic dr);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.drain_req = dr;
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [15:0] a, input logic [15:0] d);
    chk({tag, "_we"},   bus.mem_write_en,    1);
    chk({tag, "_addr"}, bus.mem_access_addr, a);
    chk({tag, "_data"}, bus.mem_write_data,  d);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    drive(0, 0, 16'h0, 16'h0, 0);
    repeat (2) tick();
    chk("rst_count", bus.sb_count, 0);
    chk("rst_empty", bus.sb_empty, 1);
    chk("rst_rspv", bus.rsp_valid, 0);
    chk("rst_rspd", bus.rsp_data, 0);
    chk("rst_we", bus.mem_write_en, 0);
    chk("rst_rd", bus.mem_read, 0);
    chk("rst_ready", bus.req_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single store, then idle drain
    drive(1, 1, 16'h0002, 16'h00A5, 0);
    chk("st_ready", bus.req_ready, 1);
    chk("st_acc_we", bus.mem_write_en, 0);
    tick();
    drive(0, 0, 16'h0, 16'h0, 0);
    chk("st_count", bus.sb_count, 1);
    chk_wr("st_drain", 16'h0002, 16'h00A5);
    tick();
    chk("st_empty", bus.sb_empty, 1);
    chk("st_idle_we", bus.mem_write_en, 0);
    chk("st_idle_addr", bus.mem_access_addr, 0);
    chk("st_mem2", mem[2], 16'h00A5);

    // Forwarding: youngest of two stores to addr 3, then alias addr 11
    drive(1, 1, 16'h0003, 16'h1111, 0);
    chk("fw_we0", bus.mem_write_en, 0);
    tick();
    drive(1, 1, 16'h0003, 16'h2222, 0);
    chk("fw_we1", bus.mem_write_en, 0);
    tick();
    drive(1, 0, 16'h0003, 16'h0, 0);
    chk("fw_rd", bus.mem_read, 1);
    chk("fw_rd_addr", bus.mem_access_addr, 16'h0003);
    chk("fw_we2", bus.mem_write_en, 0);
    tick();
    drive(1, 0, 16'h000B, 16'h0, 0);
    chk("fw_rspv", bus.rsp_valid, 1);
    chk("fw_rspd", bus.rsp_data, 16'h2222);
    chk("fw_alias_rd", bus.mem_read, 1);
    chk("fw_alias_addr", bus.mem_access_addr, 16'h000B);
    chk("fw_we3", bus.mem_write_en, 0);
    tick();
    drive(0, 0, 16'h0, 16'h0, 0);
    chk("fw_alias_rspv", bus.rsp_valid, 1);
    chk("fw_alias_rspd", bus.rsp_data, 16'h2222);
    chk_wr("fw_drain0", 16'h0003, 16'h1111);
    tick();
    chk("fw_rspv_pulse", bus.rsp_valid, 0);
    chk("fw_rspd_hold", bus.rsp_data, 16'h2222);
    chk_wr("fw_drain1", 16'h0003, 16'h2222);
    tick();
    chk("fw_empty", bus.sb_empty, 1);
    chk("fw_mem3", mem[3], 16'h2222);

    // Full buffer: 4 stores, 5th held until one entry drains
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 16'(i), 16'h0010 + 16'(i), 0);
      chk("full_ready", bus.req_ready, 1);
      tick();
    end
    drive(1, 1, 16'h0004, 16'h0014, 0);
    chk("full_count", bus.sb_count, 4);
    chk("full_ready0", bus.req_ready, 0);
    chk_wr("full_drain0", 16'h0000, 16'h0010);
    tick();
    chk("full_count3", bus.sb_count, 3);
    chk("full_ready1", bus.req_ready, 1);
    chk("full_acc_we", bus.mem_write_en, 0);
    tick();
    drive(0, 0, 16'h0, 16'h0, 0);
    chk("full_count4", bus.sb_count, 4);
    chk_wr("full_drain1", 16'h0001, 16'h0011);
    tick();
    chk_wr("full_drain2", 16'h0002, 16'h0012);
    tick();
    chk_wr("full_drain3", 16'h0003, 16'h0013);
    tick();
    chk_wr("full_drain4", 16'h0004, 16'h0014);
    tick();
    chk("full_empty", bus.sb_empty, 1);
    chk("full_mem0", mem[0], 16'h0010);
    chk("full_mem4", mem[4], 16'h0014);

    // drain_req blocks requests and empties the buffer in order
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 16'(i), 16'h0020 + 16'(i), 0);
      tick();
    end
    drive(1, 1, 16'h0007, 16'h0077, 1);
    chk("dr_ready", bus.req_ready, 0);
    chk_wr("dr_w0", 16'h0000, 16'h0020);
    tick();
    chk("dr_ready1", bus.req_ready, 0);
    chk_wr("dr_w1", 16'h0001, 16'h0021);
    tick();
    chk_wr("dr_w2", 16'h0002, 16'h0022);
    tick();
    chk("dr_empty", bus.sb_empty, 1);
    chk("dr_idle_we", bus.mem_write_en, 0);
    chk("dr_mem7", mem[7], 16'h0000);
    drive(0, 0, 16'h0, 16'h0, 0);
    tick();

    // Load miss reads memory
    drive(1, 0, 16'h0005, 16'h0, 0);
    chk("miss_rd", bus.mem_read, 1);
    chk("miss_addr", bus.mem_access_addr, 16'h0005);
    chk("miss_we", bus.mem_write_en, 0);
    tick();
    drive(0, 0, 16'h0, 16'h0, 0);
    chk("miss_rspv", bus.rsp_valid, 1);
    chk("miss_rspd", bus.rsp_data, 16'h0F0F);
    tick();
    chk("miss_rspv0", bus.rsp_valid, 0);
    chk("miss_rspd_hold", bus.rsp_data, 16'h0F0F);

    // Reset mid-run discards buffered stores
    for (int i = 5; i < 8; i++) begin
      drive(1, 1, 16'(i), 16'hAAAA, 0);
      tick();
    end
    rst_n = 1'b0;
    drive(0, 0, 16'h0, 16'h0, 0);
    chk("mrst_count", bus.sb_count, 0);
    chk("mrst_empty", bus.sb_empty, 1);
    chk("mrst_rspv", bus.rsp_valid, 0);
    chk("mrst_rspd", bus.rsp_data, 0);
    chk("mrst_we", bus.mem_write_en, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_post_we", bus.mem_write_en, 0);
    end
    chk("mrst_mem5", mem[5], 16'h0F0F);
    chk("mrst_mem6", mem[6], 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
